wam_game_ctrl: RTL and testbench
================================

// Module: wam_game_ctrl
// PURPOSE
//  Whack-a-mole game engine feeding the board I/O top: spawns moles, times their life, scores taps, runs the countdown.
//  Consumes debounced tap[7:0] and difficulty hrdn[3:0]; produces holes, BCD score, time_display and pause.
//  holes/score/time_display/pause connect directly to the display/LED top's inputs of the same names.
// PARAMETERS
//  TICK_DIV      500000  clk cycles per game tick (100 Hz at 50 MHz)
//  TICKS_PER_SEC 100     game ticks per countdown second
//  GAME_SECS     30      round length in seconds (<=31)
//  LIFE_BASE     120     mole lifetime in ticks at hrdn=0
//  SPAWN_BASE    80      ticks between spawn attempts at hrdn=0
//  MAX_MOLES     3       max simultaneously lit holes
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  start         in   1   start/restart request, level; rising edge detected internally
//  hrdn          in   4   difficulty, sampled at round start
//  tap           in   8   player hit switches, level; rising edge per bit = one strike
//  holes         out  8   1 = mole present in hole i
//  score         out  12  3-digit BCD hits, {hund,tens,ones}
//  time_display  out  5   seconds remaining, binary
//  pause         out  1   1 when no round is running
//  game_over     out  1   1 in OVER state
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, holes=0, score=0, time_display=GAME_SECS, pause=1, game_over=0,
//   prescaler/tick/sec counters=0, all life counters=0, LFSR=8'hA5 (never 0), edge registers=0.
//  Tick: prescaler counts 0..TICK_DIV-1; tick_en is a 1-cycle pulse on wrap; runs only in PLAY, cleared on entry to PLAY.
//  FSM: IDLE -start edge-> PLAY; PLAY -time_display reaches 0-> OVER; OVER -start edge-> PLAY. Start edge in PLAY ignored.
//  Entering PLAY (cycle after start edge): score=0, holes=0, time_display=GAME_SECS, latch hrdn into hrdn_q.
//  Countdown: sec counter counts ticks; at TICKS_PER_SEC ticks time_display decrements. Reaching 0 -> OVER in the same
//   cycle: holes cleared, pause=1, game_over=1, score frozen.
//  Lifetime L = max(LIFE_BASE - 6*hrdn_q, 16); spawn interval S = max(SPAWN_BASE - 4*hrdn_q, 10) ticks.
//  Spawn: spawn counter counts ticks to S; on expiry, idx = LFSR[2:0]; if holes[idx]=0 and popcount(holes)<MAX_MOLES,
//   set holes[idx], life[idx]=L; else attempt dropped (no retry). LFSR (x^8+x^6+x^5+x^4+1) advances every clk in any state.
//  Expiry: each tick, every lit hole decrements life[i]; life reaching 0 clears holes[i] (no score change).
//  Hit: tap_rise[i] = tap[i] & ~tap_q[i]. In PLAY, tap_rise[i] & holes[i] -> holes[i]=0, score+1 next cycle.
//   tap_rise on an empty hole: no effect. Taps outside PLAY ignored.
//  Multiple hits same cycle: score adds popcount of hit holes (0..MAX_MOLES), BCD-correct with per-digit carry.
//  Score saturates at 12'h999; never wraps.
//  Same-cycle conflicts: hit beats expiry (scored); spawn onto a hole being hit or expiring is suppressed;
//   countdown reaching 0 beats hits in that cycle (not scored).
//  Outputs are registered; hit-to-holes/score latency is 1 clk from the tap edge being sampled.
//  rst_n low mid-round: immediate return to reset values above; round is lost.
//  holes never has more than MAX_MOLES bits set; time_display never exceeds GAME_SECS.
// TESTING (TICK_DIV=4, TICKS_PER_SEC=10, GAME_SECS=3, hrdn=0)
//  1 Reset then idle 200 clk -> holes=0, score=0, time_display=3, pause=1, game_over=0.
//  2 start pulse -> pause=0 next clk; time_display 3->2 after 40 clk, reaches 0 at 120 clk -> game_over=1, holes=0.
//  3 Force mole in hole 5 (wait for holes[5]), tap[5] 0->1 -> holes[5]=0 and score=12'h001 1 clk later; hold tap high -> no extra score.
//  4 Preload score 12'h099 via 99 hits, hit once more -> 12'h100; at 12'h999 further hits -> stays 12'h999.
//  5 Lit hole, no tap, LIFE_BASE ticks (hrdn=0 -> 120 ticks) -> hole clears, score unchanged; tap on same cycle as expiry -> scored.
//  6 rst_n low mid-round with holes!=0, score=12'h007 -> all outputs to reset values asynchronously; start in OVER -> score 0.

Source files
------------

// File: rtl/wam_game_ctrl.sv
// Whack-a-mole game engine: spawns moles from an LFSR, times each mole's life,
// scores player taps in BCD and runs the round countdown.
module wam_game_ctrl #(
    parameter int TICK_DIV      = 500000,
    parameter int TICKS_PER_SEC = 100,
    parameter int GAME_SECS     = 30,
    parameter int LIFE_BASE     = 120,
    parameter int SPAWN_BASE    = 80,
    parameter int MAX_MOLES     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  hrdn,
    input  logic [7:0]  tap,
    output logic [7:0]  holes,
    output logic [11:0] score,
    output logic [4:0]  time_display,
    output logic        pause,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    state_t        r_state;
    state_t        w_next_state;
    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_sec;
    logic [7:0]    r_spawn_cnt;
    logic [7:0]    r_life [8];
    logic [7:0]    r_lfsr;
    logic          r_start_q;
    logic [7:0]    r_tap_q;
    logic [3:0]    r_hrdn_q;
    logic [7:0]    r_holes;
    logic [11:0]   r_score;
    logic [4:0]    r_time;

    logic          w_playing;
    logic          w_start_rise;
    logic          w_enter_play;
    logic          w_tick;
    logic          w_sec_wrap;
    logic          w_round_end;
    logic [7:0]    w_life_dec;
    logic [7:0]    w_life_len;
    logic [7:0]    w_spawn_dec;
    logic [7:0]    w_spawn_len;
    logic          w_spawn_due;
    logic [2:0]    w_idx;
    logic [3:0]    w_lit_count;
    logic [3:0]    w_hit_count;
    logic [7:0]    w_tap_rise;
    logic [7:0]    w_hit;
    logic [7:0]    w_expire;
    logic [7:0]    w_clear;
    logic [7:0]    w_spawn_mask;
    logic [7:0]    w_holes_next;
    logic [4:0]    w_ones;
    logic [4:0]    w_tens;
    logic [4:0]    w_hund;
    logic [11:0]   w_score_next;
    logic          w_lfsr_fb;

    assign holes        = r_holes;
    assign score        = r_score;
    assign time_display = r_time;

    assign w_start_rise = start & ~r_start_q;
    assign w_enter_play = (r_state != PLAY) && w_start_rise;
    assign w_tick       = w_playing && (r_presc == PW'(TICK_DIV - 1));
    assign w_sec_wrap   = w_tick && (r_sec == SW'(TICKS_PER_SEC - 1));
    assign w_round_end  = w_sec_wrap && (r_time == 5'd1);

    // Difficulty shortens mole life and spawn interval, each clamped to a floor.
    assign w_life_dec   = 8'(r_hrdn_q) * 8'd6;
    assign w_life_len   = (8'(LIFE_BASE) >= w_life_dec + 8'd16) ? 8'(LIFE_BASE) - w_life_dec : 8'd16;
    assign w_spawn_dec  = 8'(r_hrdn_q) * 8'd4;
    assign w_spawn_len  = (8'(SPAWN_BASE) >= w_spawn_dec + 8'd10) ? 8'(SPAWN_BASE) - w_spawn_dec : 8'd10;
    assign w_spawn_due  = w_tick && (r_spawn_cnt == w_spawn_len - 8'd1);
    assign w_idx        = r_lfsr[2:0];
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    assign w_tap_rise   = tap & ~r_tap_q;
    assign w_hit        = w_playing ? (w_tap_rise & r_holes) : 8'd0;
    assign w_clear      = w_hit | w_expire;
    assign w_spawn_mask = (w_spawn_due && !r_holes[w_idx] && (w_lit_count < 4'(MAX_MOLES)))
                          ? (8'd1 << w_idx) : 8'd0;
    assign w_holes_next = (r_holes & ~w_clear) | w_spawn_mask;

    // Count lit holes, count hits, and flag holes whose life runs out this tick.
    always_comb begin
        w_lit_count = 4'd0;
        w_hit_count = 4'd0;
        w_expire    = 8'd0;
        for (int i = 0; i < 8; i++) begin
            w_lit_count = w_lit_count + 4'(r_holes[i]);
            w_hit_count = w_hit_count + 4'(w_hit[i]);
            w_expire[i] = w_tick && r_holes[i] && (r_life[i] == 8'd1);
        end
    end

    // Add this cycle's hits to the BCD score with per-digit carry, saturating at 999.
    always_comb begin
        w_ones = 5'(r_score[3:0]) + 5'(w_hit_count);
        w_tens = 5'(r_score[7:4]);
        w_hund = 5'(r_score[11:8]);
        if (w_ones >= 5'd10) begin
            w_ones = w_ones - 5'd10;
            w_tens = w_tens + 5'd1;
        end
        if (w_tens >= 5'd10) begin
            w_tens = w_tens - 5'd10;
            w_hund = w_hund + 5'd1;
        end
        if (w_hund >= 5'd10) begin
            w_score_next = 12'h999;
        end else begin
            w_score_next = {w_hund[3:0], w_tens[3:0], w_ones[3:0]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a start edge launches a round, the countdown hitting zero ends it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_rise) w_next_state = PLAY;
            PLAY:    if (w_round_end)  w_next_state = OVER;
            OVER:    if (w_start_rise) w_next_state = PLAY;
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_playing = (r_state == PLAY);
        pause     = (r_state != PLAY);
        game_over = (r_state == OVER);
    end

    // Game datapath: edge capture, LFSR, tick/second/spawn counters, moles and score.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= '0;
            r_sec       <= '0;
            r_spawn_cnt <= 8'd0;
            r_lfsr      <= 8'hA5;
            r_start_q   <= 1'b0;
            r_tap_q     <= 8'd0;
            r_hrdn_q    <= 4'd0;
            r_holes     <= 8'd0;
            r_score     <= 12'h000;
            r_time      <= 5'(GAME_SECS);
            for (int i = 0; i < 8; i++) r_life[i] <= 8'd0;
        end else begin
            r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
            r_start_q <= start;
            r_tap_q   <= tap;
            if (w_enter_play) begin
                r_presc     <= '0;
                r_sec       <= '0;
                r_spawn_cnt <= 8'd0;
                r_hrdn_q    <= hrdn;
                r_holes     <= 8'd0;
                r_score     <= 12'h000;
                r_time      <= 5'(GAME_SECS);
                for (int i = 0; i < 8; i++) r_life[i] <= 8'd0;
            end else if (w_playing) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_tick) begin
                    r_sec       <= w_sec_wrap ? '0 : r_sec + SW'(1);
                    r_spawn_cnt <= w_spawn_due ? 8'd0 : r_spawn_cnt + 8'd1;
                end
                if (w_sec_wrap) begin
                    r_time <= r_time - 5'd1;
                end
                if (w_round_end) begin
                    r_holes <= 8'd0;
                    for (int i = 0; i < 8; i++) r_life[i] <= 8'd0;
                end else begin
                    r_holes <= w_holes_next;
                    r_score <= w_score_next;
                    for (int i = 0; i < 8; i++) begin
                        if (w_clear[i]) begin
                            r_life[i] <= 8'd0;
                        end else if (w_spawn_mask[i]) begin
                            r_life[i] <= w_life_len;
                        end else if (w_tick && r_holes[i]) begin
                            r_life[i] <= r_life[i] - 8'd1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_wam_game_ctrl.sv
// Directed testbench for wam_game_ctrl. Shortened timing parameters keep a
// 31-second round at 24800 clocks so that lifetimes, saturation and the full
// countdown all fit inside real rounds.
module tb_wam_game_ctrl;

    localparam int TD  = 2;
    localparam int TPS = 400;
    localparam int GS  = 31;
    localparam int LB  = 120;
    localparam int SB  = 70;
    localparam int MM  = 3;
    localparam int CPS = TD * TPS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  hrdn;
    logic [7:0]  tap;
    logic [7:0]  holes;
    logic [11:0] score;
    logic [4:0]  time_display;
    logic        pause;
    logic        game_over;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int hits   = 0;

    wam_game_ctrl #(
        .TICK_DIV(TD), .TICKS_PER_SEC(TPS), .GAME_SECS(GS),
        .LIFE_BASE(LB), .SPAWN_BASE(SB), .MAX_MOLES(MM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hrdn(hrdn), .tap(tap),
        .holes(holes), .score(score), .time_display(time_display),
        .pause(pause), .game_over(game_over)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) stepClk();
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] t);
        start = s;
        tap   = t;
        stepClk();
    endtask

    function automatic int popc(input logic [7:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [7:0] lowBit(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic logic [11:0] toBcd(input int n);
        int m;
        m = (n > 999) ? 999 : n;
        return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic waitNewHole(input int bound, output logic [7:0] mask);
        logic [7:0] prev;
        mask = 8'd0;
        for (int k = 0; k < bound && mask == 8'd0; k++) begin
            prev = holes;
            stepClk();
            mask = lowBit(holes & ~prev);
        end
        if (mask == 8'd0) checkOutput("waitNewHole", 0, 1);
    endtask

    task automatic hitMask(input logic [7:0] m);
        tap = m;
        stepClk();
        hits += popc(m);
        checkOutput("hitScore", 32'(score), 32'(toBcd(hits)));
        checkOutput("hitClear", 32'(holes & m), 0);
        tap = 8'd0;
    endtask

    initial begin
        logic [7:0] maskA;
        logic [7:0] m;
        int         v;

        rst_n = 1'b0;
        start = 1'b0;
        hrdn  = 4'd0;
        tap   = 8'd0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (200) stepClk();
        checkOutput("idleHoles", 32'(holes), 0);
        checkOutput("idleScore", 32'(score), 0);
        checkOutput("idleTime", 32'(time_display), GS);
        checkOutput("idlePause", 32'(pause), 1);
        checkOutput("idleOver", 32'(game_over), 0);

        applyStimulus(1'b0, 8'hFF);
        applyStimulus(1'b0, 8'h00);
        checkOutput("idleTapScore", 32'(score), 0);

        // Round 1 at hrdn=0: life 120 ticks, spawn every 70 ticks.
        hrdn = 4'd0;
        applyStimulus(1'b1, 8'h00);
        cyc   = 0;
        start = 1'b0;
        checkOutput("playPause", 32'(pause), 0);
        checkOutput("playTime", 32'(time_display), GS);
        checkOutput("playHoles", 32'(holes), 0);

        stepTo(SB * TD - 1);
        checkOutput("preSpawn", 32'(holes), 0);
        stepTo(SB * TD);
        checkOutput("firstSpawn", popc(holes), 1);
        maskA = holes;
        stepTo(SB * TD + LB * TD - 1);
        checkOutput("lifeAlive", 32'(holes & maskA), 32'(maskA));
        stepTo(SB * TD + LB * TD);
        checkOutput("lifeExpire", 32'(holes & maskA), 0);
        checkOutput("expireNoScore", 32'(score), 0);

        stepTo(CPS - 1);
        checkOutput("time31", 32'(time_display), GS);
        stepTo(CPS);
        checkOutput("time30", 32'(time_display), GS - 1);

        // Tap lands in the very cycle the mole expires: hit wins.
        waitNewHole(600, m);
        v = cyc;
        stepTo(v + LB * TD - 1);
        checkOutput("expTapAlive", 32'(holes & m), 32'(m));
        hitMask(m);

        // Plain hit, then a held tap must not score again.
        waitNewHole(600, m);
        hitMask(m);
        tap = m;
        repeat (5) stepClk();
        checkOutput("holdNoScore", 32'(score), 32'(toBcd(hits)));
        tap = 8'd0;
        stepClk();

        // Tap on an empty hole.
        tap = lowBit(~holes);
        stepClk();
        tap = 8'd0;
        checkOutput("emptyTap", 32'(score), 32'(toBcd(hits)));

        // Two moles struck in the same cycle.
        for (int k = 0; k < 2000 && popc(holes) < 2; k++) stepClk();
        if (popc(holes) < 2) checkOutput("waitTwoMoles", popc(holes), 2);
        hitMask(holes);

        for (int k = 0; k < 10 && hits < 7; k++) begin
            waitNewHole(600, m);
            hitMask(m);
        end

        // A start edge mid-round is ignored.
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("startInPlay", 32'(time_display), GS - cyc / CPS);
        checkOutput("startInPlayPause", 32'(pause), 0);

        if (holes == 8'd0) waitNewHole(600, m);
        checkOutput("preResetScore", 32'(score), 32'h007);
        checkOutput("preResetHoles", 32'(holes != 8'd0), 1);

        // Asynchronous reset mid-round.
        rst_n = 1'b0;
        #2;
        checkOutput("rstHoles", 32'(holes), 0);
        checkOutput("rstScore", 32'(score), 0);
        checkOutput("rstTime", 32'(time_display), GS);
        checkOutput("rstPause", 32'(pause), 1);
        checkOutput("rstOver", 32'(game_over), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        stepClk();
        stepClk();
        checkOutput("postRstPause", 32'(pause), 1);

        // Round 2 at hrdn=15: life 30 ticks, spawn every 10 ticks.
        hrdn = 4'd15;
        applyStimulus(1'b1, 8'h00);
        cyc   = 0;
        hits  = 0;
        start = 1'b0;
        checkOutput("r2Score", 32'(score), 0);
        stepTo(10 * TD - 1);
        checkOutput("r2PreSpawn", 32'(holes), 0);
        stepTo(10 * TD);
        checkOutput("r2Spawn", popc(holes), 1);
        hitMask(holes);
        for (int k = 0; k < 1100 && hits < 1003; k++) begin
            waitNewHole(60, m);
            hitMask(m);
        end
        checkOutput("saturated", 32'(score), 32'h999);

        waitNewHole(60, m);
        v = cyc;
        stepTo(v + 30 * TD - 1);
        checkOutput("r2LifeAlive", 32'(holes & m), 32'(m));
        stepTo(v + 30 * TD);
        checkOutput("r2LifeExpire", 32'(holes & m), 0);

        stepTo(GS * CPS - 1);
        checkOutput("lastSecTime", 32'(time_display), 1);
        checkOutput("lastSecOver", 32'(game_over), 0);
        stepTo(GS * CPS);
        checkOutput("endTime", 32'(time_display), 0);
        checkOutput("endOver", 32'(game_over), 1);
        checkOutput("endPause", 32'(pause), 1);
        checkOutput("endHoles", 32'(holes), 0);

        applyStimulus(1'b0, 8'hFF);
        applyStimulus(1'b0, 8'h00);
        checkOutput("overTapScore", 32'(score), 32'h999);
        checkOutput("overHoles", 32'(holes), 0);

        // Restart from OVER clears the score.
        applyStimulus(1'b1, 8'h00);
        start = 1'b0;
        checkOutput("restartScore", 32'(score), 0);
        checkOutput("restartPause", 32'(pause), 0);
        checkOutput("restartOver", 32'(game_over), 0);
        checkOutput("restartTime", 32'(time_display), GS);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
